// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that lets two requesters load or clear one shared register.
// Each granted write goes through WRITE, CHECK and DONE, then acks with a readback-mismatch flag.
module reg_load_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic         req_b,
  input  logic         op_a,
  input  logic         op_b,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  input  logic [W-1:0] reg_q,
  output logic         ack_a,
  output logic         ack_b,
  output logic         err,
  output logic         busy,
  output logic         reg_ld,
  output logic         reg_clr,
  output logic [W-1:0] reg_d
);

  typedef enum logic [1:0] {IDLE, WRITE, CHECK, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           ptr_b;
  logic           win_b;
  logic           op_q;
  logic           err_q;
  logic [W-1:0]   data_q;
  logic           grant_b;

  // B wins when it is the only requester, or when both request and the pointer is on B
  assign grant_b = req_b & (~req_a | ptr_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_b  <= 1'b0;
      win_b  <= 1'b0;
      op_q   <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && (req_a || req_b)) begin
        win_b  <= grant_b;
        op_q   <= grant_b ? op_b : op_a;
        data_q <= grant_b ? data_b : data_a;
        ptr_b  <= ~grant_b;
      end
      if (state == CHECK)
        err_q <= (reg_q != (op_q ? '0 : data_q));
    end
  end

  always_comb begin
    state_nxt = state;
    ack_a     = 1'b0;
    ack_b     = 1'b0;
    err       = 1'b0;
    busy      = 1'b0;
    reg_ld    = 1'b0;
    reg_clr   = 1'b0;
    reg_d     = data_q;
    case (state)
      IDLE: begin
        if (req_a || req_b) state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        reg_ld    = ~op_q;
        reg_clr   = op_q;
        // a clear carries no data, so present zero rather than the stale latch
        if (op_q) reg_d = '0;
        state_nxt = CHECK;
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        ack_a     = ~win_b;
        ack_b     = win_b;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Bench for reg_load_arbiter: directed scenarios with literal expectations, then random
// two-requester traffic compared every cycle against a transaction-level model.
module tb_reg_load_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_a = 1'b0, req_b = 1'b0, op_a = 1'b0, op_b = 1'b0;
  logic [W-1:0] data_a = '0, data_b = '0;
  logic [W-1:0] reg_q;
  logic         ack_a, ack_b, err, busy, reg_ld, reg_clr;
  logic [W-1:0] reg_d;

  logic [W-1:0] reg_val = '0;
  logic [W-1:0] flip = '0;
  logic         force_en = 1'b0;
  logic [W-1:0] force_val = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // transaction model: latest grant cycle and what was granted
  int           m_g = -100;
  int           m_next_free = 0;
  logic         m_ptr = 1'b0;
  logic         m_win = 1'b0;
  logic         m_op = 1'b0;
  logic [W-1:0] m_data = '0;
  logic         m_err = 1'b0;

  reg_load_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .data_a(data_a), .data_b(data_b), .reg_q(reg_q),
    .ack_a(ack_a), .ack_b(ack_b), .err(err), .busy(busy),
    .reg_ld(reg_ld), .reg_clr(reg_clr), .reg_d(reg_d)
  );

  always #5 clk = ~clk;

  assign reg_q = force_en ? force_val : (reg_val ^ flip);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_clr)     reg_val <= '0;
    else if (reg_ld) reg_val <= reg_d;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic ra, input logic oa, input logic [W-1:0] da,
                                input logic rb, input logic ob, input logic [W-1:0] db);
    req_a = ra; op_a = oa; data_a = da;
    req_b = rb; op_b = ob; data_b = db;
  endtask

  // model: grant whenever free and someone asks; the result is fixed by reg_q two cycles later
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_g = -100; m_next_free = 0; m_ptr = 1'b0; m_win = 1'b0;
      m_op = 1'b0; m_data = '0; m_err = 1'b0;
    end else begin
      if (cyc == m_g + 2) m_err = (reg_q != (m_op ? {W{1'b0}} : m_data));
      if (cyc >= m_next_free && (req_a || req_b)) begin
        m_win = req_a && req_b ? m_ptr : req_b;
        m_op = m_win ? op_b : op_a;
        m_data = m_win ? data_b : data_a;
        m_ptr = ~m_win;
        m_g = cyc;
        m_next_free = cyc + 4;
      end
    end
  end

  always @(negedge clk) begin
    logic in_write, in_done;
    logic [W-1:0] exp_d;
    in_write = rst && (cyc == m_g + 1);
    in_done  = rst && (cyc == m_g + 3);
    exp_d    = (!rst) ? {W{1'b0}} : ((in_write && m_op) ? {W{1'b0}} : m_data);
    check_output("busy", 32'(busy), 32'(rst && cyc > m_g && cyc <= m_g + 3));
    check_output("reg_ld", 32'(reg_ld), 32'(in_write && !m_op));
    check_output("reg_clr", 32'(reg_clr), 32'(in_write && m_op));
    check_output("reg_d", 32'(reg_d), 32'(exp_d));
    check_output("ack_a", 32'(ack_a), 32'(in_done && !m_win));
    check_output("ack_b", 32'(ack_b), 32'(in_done && m_win));
    check_output("err", 32'(err), 32'(in_done && m_err));
  end

  initial begin
    bit seen;
    apply_stimulus(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_reg_d", 32'(reg_d), 32'd0);
    rst = 1'b1;
    tick();

    // single load of A, with data_a changed after the grant
    apply_stimulus(1, 0, 4'hA, 0, 0, 0);
    tick();
    check_output("load_ld", 32'(reg_ld), 32'd1);
    check_output("load_d", 32'(reg_d), 32'hA);
    check_output("load_busy1", 32'(busy), 32'd1);
    apply_stimulus(1, 0, 4'hF, 0, 0, 0);
    tick();
    check_output("load_hold_d", 32'(reg_d), 32'hA);
    check_output("load_busy2", 32'(busy), 32'd1);
    tick();
    check_output("load_ack", 32'(ack_a), 32'd1);
    check_output("load_err", 32'(err), 32'd0);
    apply_stimulus(0, 0, 4'hF, 0, 0, 0);
    tick();
    check_output("load_idle", 32'(busy), 32'd0);

    // contention right after reset: A, B, A, B
    #1 rst = 1'b0;
    tick();
    rst = 1'b1;
    apply_stimulus(1, 0, 4'h1, 1, 0, 4'h2);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1)  check_output("cont_first", 32'(reg_d), 32'h1);
      if (k == 3)  check_output("cont_ack1", {30'd0, ack_b, ack_a}, 32'b01);
      if (k == 7)  check_output("cont_ack2", {30'd0, ack_b, ack_a}, 32'b10);
      if (k == 11) check_output("cont_ack3", {30'd0, ack_b, ack_a}, 32'b01);
      if (k == 15) begin
        check_output("cont_ack4", {30'd0, ack_b, ack_a}, 32'b10);
        apply_stimulus(0, 0, 0, 0, 0, 0);
      end
    end

    // put 5 in the register, then clear it from B
    apply_stimulus(1, 0, 4'h5, 0, 0, 0);
    repeat (3) tick();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick();
    apply_stimulus(0, 0, 0, 1, 1, 4'hC);
    tick();
    check_output("clr_clr", 32'(reg_clr), 32'd1);
    check_output("clr_ld", 32'(reg_ld), 32'd0);
    repeat (2) tick();
    check_output("clr_ack", 32'(ack_b), 32'd1);
    check_output("clr_err", 32'(err), 32'd0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick();

    // readback stuck at 3 while loading 7
    force_en = 1'b1; force_val = 4'h3;
    apply_stimulus(1, 0, 4'h7, 0, 0, 0);
    repeat (3) tick();
    check_output("mis_ack", 32'(ack_a), 32'd1);
    check_output("mis_err", 32'(err), 32'd1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick();
    check_output("mis_err_clr", 32'(err), 32'd0);
    force_en = 1'b0;

    // reset during WRITE, then both request; pointer must be back on A
    apply_stimulus(1, 0, 4'h6, 1, 0, 4'h9);
    tick();
    #1 rst = 1'b0;
    #1;
    check_output("abort_ld", 32'(reg_ld), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_ack", {30'd0, ack_b, ack_a}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check_output("abort_regrant", 32'(reg_d), 32'h6);
    repeat (2) tick();
    check_output("abort_ack_a", 32'(ack_a), 32'd1);
    apply_stimulus(0, 0, 0, 1, 0, 4'h9);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (ack_b) seen = 1'b1;
    end
    check_output("abort_ack_b_seen", 32'(seen), 32'd1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick();

    // random traffic on both requesters with occasional readback corruption and resets
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (ack_a) begin
        if ($urandom_range(0, 3) == 0) begin op_a = 1'($urandom_range(0, 1)); data_a = W'($urandom); end
        else req_a = 1'b0;
      end else if (!req_a) begin
        if ($urandom_range(0, 2) == 0) begin req_a = 1'b1; op_a = 1'($urandom_range(0, 1)); data_a = W'($urandom); end
      end else if ($urandom_range(0, 3) == 0) begin
        op_a = 1'($urandom_range(0, 1)); data_a = W'($urandom);
      end
      if (ack_b) begin
        if ($urandom_range(0, 3) == 0) begin op_b = 1'($urandom_range(0, 1)); data_b = W'($urandom); end
        else req_b = 1'b0;
      end else if (!req_b) begin
        if ($urandom_range(0, 2) == 0) begin req_b = 1'b1; op_b = 1'($urandom_range(0, 1)); data_b = W'($urandom); end
      end else if ($urandom_range(0, 3) == 0) begin
        op_b = 1'($urandom_range(0, 1)); data_b = W'($urandom);
      end
      flip = ($urandom_range(0, 7) == 0) ? W'($urandom_range(1, 15)) : '0;
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b0;
        tick();
        rst = 1'b1;
      end
    end

    apply_stimulus(0, 0, 0, 0, 0, 0);
    flip = '0;
    repeat (6) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_load_arbiter.md
REG_LOAD_ARBITER -- requirements
Module: reg_load_arbiter

Interface
REQ-001 Parameter: W, default 4, data width of the shared parallel-load register.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 req_a, req_b  input  1 each  level request from requester A / B; held high until acknowledged.
REQ-005 op_a, op_b  input  1 each  operation: 0 = load data, 1 = clear register.
REQ-006 data_a, data_b  input  W each  load value.
REQ-007 ack_a, ack_b  output  1 each  one-cycle completion pulse to requester A / B.
REQ-008 err  output  1  readback mismatch flag; valid only while ack_a or ack_b is high.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 reg_ld, reg_clr  output  1 each  load / clear strobes to the shared register.
REQ-011 reg_d  output  W  data to the shared register.
REQ-012 reg_q  input  W  readback of the shared register output.

Function
REQ-013 The FSM SHALL have four states: IDLE, WRITE, CHECK, DONE; each of WRITE, CHECK and DONE lasts exactly one cycle.
REQ-014 In IDLE with at least one req high, the arbiter SHALL grant one requester, latch its op and data, record the winner, and go to WRITE; with no req, it SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: with a single request, that requester wins; with both requests, the requester holding the priority pointer wins.
REQ-016 The priority pointer SHALL move to the other requester after each grant.
REQ-017 In WRITE, the block SHALL drive reg_ld=1 for load or reg_clr=1 for clear, never both; reg_d SHALL equal the latched data (don't-care value 0 for clear).
REQ-018 reg_ld and reg_clr SHALL be 0 in every state other than WRITE.
REQ-019 reg_d SHALL hold the last latched data outside WRITE.
REQ-020 In CHECK, the block SHALL compare reg_q with the expected value (latched data for load, 0 for clear) and register the result as err.
REQ-021 In DONE, the block SHALL assert ack of the granted requester only, present err, and then return to IDLE.
REQ-022 Latency SHALL be 4 cycles: grant in cycle t, reg_ld/reg_clr in t+1, check in t+2, ack in t+3; the next grant is possible no earlier than t+4.
REQ-023 Changes to req, op or data of any requester after its grant SHALL be ignored until the next IDLE.
REQ-024 Requester protocol: req SHALL be deasserted in the cycle after ack is sampled; a requester that keeps req high is granted again per round-robin.
REQ-025 err SHALL be 0 whenever no ack is high.

Reset
REQ-026 While rst=0, asynchronously: state=IDLE, priority pointer=A, and ack_a, ack_b, err, busy, reg_ld, reg_clr = 0, reg_d = 0.
REQ-027 Reset asserted mid-transaction SHALL abort the transaction with no ack; the first grant after release follows REQ-014 with pointer=A.

Verification
REQ-028 Single load: req_a=1, op_a=0, data_a=4'hA -> reg_ld=1 with reg_d=4'hA in t+1; ack_a=1 and err=0 in t+3; busy=1 during t+1..t+3.
REQ-029 Contention: req_a and req_b both held high after reset -> grant order A, B, A, B; acks in cycles 3, 7, 11, 15 after the first grant cycle.
REQ-030 Clear: register holds 4'h5; req_b=1, op_b=1 -> reg_clr=1 and reg_ld=0 in t+1; ack_b=1 and err=0 in t+3.
REQ-031 Mismatch: reg_q forced to 4'h3; load 4'h7 -> ack=1 with err=1 in t+3; err=0 in the next cycle.
REQ-032 Reset abort: rst=0 during WRITE -> reg_ld, busy and ack drop to 0 immediately without waiting for clk; after release with both requests, A is granted first.
REQ-033 Post-grant change: data_a changed from 4'h2 to 4'hF in t+1 -> reg_d=4'h2 in t+1.
